// File: rtl/keypad_emulator.sv
// keypad_emulator: responder side of a 4x4 column-drive/row-sense key matrix that plays
// each accepted key request as press bounce, hold, release bounce and gap. Macro: KEYEMU_BOUNCE_EN.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 1000,
  parameter int BOUNCE_LEN    = 16,
  parameter int BOUNCE_PERIOD = 4,
  parameter int GAP_CYCLES    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_key,
  input  logic [15:0] req_hold,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          PW       = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(BOUNCE_PERIOD - 1);
  localparam logic [15:0] BL_LAST  = 16'(BOUNCE_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] HOLD_DEF = 16'(HOLD_CYCLES);

  typedef enum logic [2:0] {IDLE, PRESS_B, HELD, REL_B, GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_cnt, w_cnt_nxt;
  logic [PW-1:0] r_phase, w_phase_nxt;
  logic          r_contact, w_contact_nxt;
  logic [7:0]    r_key_q, w_key_nxt;
  logic [15:0]   r_hold_q, w_hold_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          w_key_ok;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
  endfunction

  assign w_key_ok = is_onehot4(req_key[7:4]) && is_onehot4(req_key[3:0]);

  // r_phase tracks cnt % BOUNCE_PERIOD without a divider; it restarts with cnt on every state entry.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 16'd1;
    w_phase_nxt   = (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
    w_contact_nxt = r_contact;
    w_key_nxt     = r_key_q;
    w_hold_nxt    = r_hold_q;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt   = '0;
        w_phase_nxt = '0;
        if (req_valid) begin
          if (w_key_ok) begin
            w_key_nxt     = req_key;
            w_hold_nxt    = (req_hold == 16'd0) ? HOLD_DEF : req_hold;
            w_contact_nxt = 1'b1;
`ifdef KEYEMU_BOUNCE_EN
            w_state_nxt   = PRESS_B;
`else
            w_state_nxt   = HELD;
`endif
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      PRESS_B: begin
        if (r_phase == PH_LAST) w_contact_nxt = ~r_contact;
        if (r_cnt == BL_LAST) begin
          w_state_nxt   = HELD;
          w_contact_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_phase_nxt   = '0;
        end
      end

      HELD: begin
        if (r_cnt == r_hold_q - 16'd1) begin
          w_contact_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_phase_nxt   = '0;
`ifdef KEYEMU_BOUNCE_EN
          w_state_nxt   = REL_B;
`else
          w_state_nxt   = GAP;
`endif
        end
      end

      REL_B: begin
        if (r_phase == PH_LAST) w_contact_nxt = ~r_contact;
        if (r_cnt == BL_LAST) begin
          w_state_nxt   = GAP;
          w_contact_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_phase_nxt   = '0;
        end
      end

      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_phase   <= '0;
      r_contact <= 1'b0;
      r_key_q   <= '0;
      r_hold_q  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_contact <= w_contact_nxt;
      r_key_q   <= w_key_nxt;
      r_hold_q  <= w_hold_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Row is a pure function of contact, key and col, so clearing contact in reset blanks it without a clock.
  assign row       = (r_contact && ((col & r_key_q[7:4]) != 4'b0)) ? r_key_q[3:0] : 4'b0;
  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: request table with a per-cycle expected-waveform
// scoreboard, plus hand sequences for column sweep, async reset and back-to-back requests.
module tb_keypad_emulator;

  localparam int BL       = 8;
  localparam int BP       = 2;
  localparam int GAP      = 10;
  localparam int HOLD_DEF = 50;
`ifdef KEYEMU_BOUNCE_EN
  localparam int OVH = 2 * BL + GAP;
`else
  localparam int OVH = GAP;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_key;
  logic [15:0] req_hold;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        busy;
  logic        done;
  logic        err;

  keypad_emulator #(
    .HOLD_CYCLES  (HOLD_DEF),
    .BOUNCE_LEN   (BL),
    .BOUNCE_PERIOD(BP),
    .GAP_CYCLES   (GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_key  (req_key),
    .req_hold (req_hold),
    .col      (col),
    .row      (row),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [3:0] row;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic [7:0]  key;
    logic [15:0] hold;
    logic [3:0]  col;
    bit          ok;
  } vec_t;

  obs_t sb[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void push_obs(input logic [3:0] r, input logic b, input logic d);
    obs_t e;
    e.row  = r;
    e.busy = b;
    e.done = d;
    sb.push_back(e);
  endfunction

  // Expected per-cycle waveform, starting with the cycle right after the accepting edge.
  function automatic void push_expected(input logic [7:0] key, input int hold_eff, input logic [3:0] c);
    logic [3:0] on_row;
    on_row = ((c & key[7:4]) != 4'b0) ? key[3:0] : 4'b0;
`ifdef KEYEMU_BOUNCE_EN
    for (int k = 0; k < BL; k++) push_obs((((k / BP) % 2) == 0) ? on_row : 4'b0, 1'b1, 1'b0);
`endif
    for (int k = 0; k < hold_eff; k++) push_obs(on_row, 1'b1, 1'b0);
`ifdef KEYEMU_BOUNCE_EN
    for (int k = 0; k < BL; k++) push_obs((((k / BP) % 2) == 1) ? on_row : 4'b0, 1'b1, 1'b0);
`endif
    for (int k = 0; k < GAP; k++) push_obs(4'b0, 1'b1, 1'b0);
    push_obs(4'b0, 1'b0, 1'b1);
    push_obs(4'b0, 1'b0, 1'b0);
  endfunction

  task automatic run_valid(input vec_t v);
    obs_t e;
    int   hold_eff;
    int   j;
    col = v.col;
    @(negedge clk);
    req_key   = v.key;
    req_hold  = v.hold;
    req_valid = 1'b1;
    #1 check($sformatf("ready before key %02h", v.key), 32'(req_ready), 32'(1));
    hold_eff = (v.hold == 16'd0) ? HOLD_DEF : int'(v.hold);
    push_expected(v.key, hold_eff, v.col);
    @(negedge clk);
    req_valid = 1'b0;
    req_key   = 8'h11;
    req_hold  = 16'd2;
    j = 0;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      #1 check($sformatf("key %02h cycle %0d {row,busy,done}", v.key, j),
               32'({row, busy, done}), 32'(e));
      @(negedge clk);
      j++;
    end
  endtask

  task automatic run_invalid(input vec_t v);
    col = v.col;
    @(negedge clk);
    req_key   = v.key;
    req_hold  = v.hold;
    req_valid = 1'b1;
    #1 check($sformatf("ready before bad key %02h", v.key), 32'(req_ready), 32'(1));
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check($sformatf("err pulse key %02h", v.key), 32'(err), 32'(1));
    check($sformatf("busy after bad key %02h", v.key), 32'(busy), 32'(0));
    check($sformatf("ready after bad key %02h", v.key), 32'(req_ready), 32'(1));
    check($sformatf("row after bad key %02h", v.key), 32'(row), 32'(0));
    @(negedge clk);
    #1;
    check($sformatf("err cleared key %02h", v.key), 32'(err), 32'(0));
    check($sformatf("busy still low key %02h", v.key), 32'(busy), 32'(0));
  endtask

  task automatic wait_done(input string name, input int budget, output int cycles);
    cycles = -1;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (done) begin
        cycles = k;
        break;
      end
      @(negedge clk);
    end
    if (cycles < 0) check({name, " timeout"}, 32'(0), 32'(1));
  endtask

  initial begin
    int cyc;
    int lows;
    int low_at;
    logic done_at_low;
    int pulses;

    vecs[0] = '{key: 8'h24, hold: 16'd20,    col: 4'b0010, ok: 1'b1};
    vecs[1] = '{key: 8'h12, hold: 16'd0,     col: 4'b0001, ok: 1'b1};
    vecs[2] = '{key: 8'h33, hold: 16'd5,     col: 4'b1111, ok: 1'b0};
    vecs[3] = '{key: 8'h48, hold: 16'd3,     col: 4'b1100, ok: 1'b1};
    vecs[4] = '{key: 8'h00, hold: 16'd5,     col: 4'b1111, ok: 1'b0};
    vecs[5] = '{key: 8'h81, hold: 16'd4,     col: 4'b0111, ok: 1'b1};
    vecs[6] = '{key: 8'h1F, hold: 16'd5,     col: 4'b0001, ok: 1'b0};
    vecs[7] = '{key: 8'h11, hold: 16'd1,     col: 4'b0001, ok: 1'b1};
    vecs[8] = '{key: 8'h18, hold: 16'hFFFF,  col: 4'b0001, ok: 1'b1};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_key   = 8'h0;
    req_hold  = 16'h0;
    col       = 4'hF;
    #2;
    check("reset row",   32'(row),       32'(0));
    check("reset ready", 32'(req_ready), 32'(1));
    check("reset busy",  32'(busy),      32'(0));
    check("reset done",  32'(done),      32'(0));
    check("reset err",   32'(err),       32'(0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].ok) run_valid(vecs[i]);
      else run_invalid(vecs[i]);
    end

    // Column sweep while key 0x81 is held.
    col = 4'b0000;
    @(negedge clk);
    req_key = 8'h81; req_hold = 16'd40; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < 4; c++) begin
        col = 4'b0001 << c;
        #1 check($sformatf("sweep col %04b", col), 32'(row), (c == 3) ? 32'(1) : 32'(0));
        @(negedge clk);
      end
    end
    col = 4'b0000;
    #1 check("col zero forces row 0", 32'(row), 32'(0));
    wait_done("sweep done", 200, cyc);
    @(negedge clk);

    // Asynchronous reset in the middle of HELD.
    col = 4'b0010;
    @(negedge clk);
    req_key = 8'h24; req_hold = 16'd40; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    #1 check("held row before reset", 32'(row), 32'(4'b0100));
    #1 reset = 1'b0;
    #1;
    check("row cleared by async reset",  32'(row),       32'(0));
    check("busy cleared by async reset", 32'(busy),      32'(0));
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("ready after reset release", 32'(req_ready), 32'(1));
    check("busy after reset release",  32'(busy),      32'(0));
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      #1 if (done) pulses++;
    end
    check("no done after reset", 32'(pulses), 32'(0));

    // Back-to-back requests with req_valid held high across done.
    col = 4'b0100;
    @(negedge clk);
    req_key = 8'h42; req_hold = 16'd5; req_valid = 1'b1;
    @(negedge clk);
    lows = 0; low_at = -1; done_at_low = 1'b0;
    for (int j = 0; j <= OVH + 6; j++) begin
      #1;
      if (!busy) begin
        lows++;
        low_at = j;
        done_at_low = done;
      end
      if (j == OVH + 6) req_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b busy-low cycles", 32'(lows),        32'(1));
    check("b2b busy-low index",  32'(low_at),      32'(OVH + 5));
    check("b2b done on gap",     32'(done_at_low), 32'(1));
    wait_done("b2b second done", 200, cyc);
    check("b2b second latency", 32'(cyc), 32'(OVH + 5 - 1));
    @(negedge clk);
    @(negedge clk);
    #1 check("idle after b2b", 32'(busy), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
